// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Brief    : Integer register file with write bypass, hardwired-zero r0 and a
//            per-register pending scoreboard with population count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter  int XLEN    = 32,
  parameter  int NREG    = 32,
  parameter  int NREAD   = 2,
  parameter  int DBG_REG = 2,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush,
  output logic [NREG-1:0]       busy_vec,
  output logic [AW:0]           npend,
  output logic [15:0]           dbg_led
);

  localparam logic [AW-1:0] DBG_IDX = AW'(DBG_REG);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     npend_q, npend_d;
  logic            wr_live, iss_live, cnt_inc, cnt_dec;

  assign wr_live  = wr_en && (wr_addr != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  always_comb begin
    rf_d = rf_q;
    if (wr_live) begin
      rf_d[wr_addr] = wr_data;
    end
  end

  // Issue beats writeback on the same register: the new producer owns it.
  always_comb begin
    pend_d = '0;
    if (!flush) begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_live && (iss_addr == AW'(r))) begin
          pend_d[r] = 1'b1;
        end else if (wr_live && (wr_addr == AW'(r))) begin
          pend_d[r] = 1'b0;
        end else begin
          pend_d[r] = pend_q[r];
        end
      end
    end
  end

  always_comb begin
    cnt_inc = iss_live && !pend_q[iss_addr];
    cnt_dec = wr_live && pend_q[wr_addr] && !(iss_live && (iss_addr == wr_addr));
    if (flush) begin
      npend_d = '0;
    end else begin
      npend_d = npend_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
      pend_q  <= '0;
      npend_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= rf_d[r];
      end
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] addr;
      logic          wr_hit;
      assign addr   = rd_addr[i*AW +: AW];
      assign wr_hit = wr_en && (wr_addr == addr);
      assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                       wr_hit       ? wr_data : rf_q[addr];
      assign rd_busy[i] = (addr != '0) && pend_q[addr] && !wr_hit;
    end
  endgenerate

  generate
    if (XLEN >= 16) begin : g_dbg_full
      assign dbg_led = rf_q[DBG_IDX][15:0];
    end else begin : g_dbg_narrow
      assign dbg_led = {{(16-XLEN){1'b0}}, rf_q[DBG_IDX]};
    end
  endgenerate

  assign busy_vec = pend_q;
  assign npend    = npend_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb against an array-based reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int NREAD   = 3;
  localparam int DBG_REG = 2;
  localparam int AW      = $clog2(NREG);

  logic                  clk;
  logic                  rstn;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic                  flush;
  logic [NREG-1:0]       busy_vec;
  logic [AW:0]           npend;
  logic [15:0]           dbg_led;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .DBG_REG(DBG_REG)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec), .npend(npend),
    .dbg_led(dbg_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic [NREG-1:0]       busy;
    logic [AW:0]           npend;
    logic [15:0]           dbg;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   done    = 0;

  // Reference state: plain arrays, count derived by popcount.
  logic [XLEN-1:0] m_rf [NREG];
  bit              m_pend [NREG];

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_rf[r]   = '0;
      m_pend[r] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus: drive at negedge, push the expected view, then
  // advance the model as the following posedge will.
  task automatic drive(input bit rs, input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit ie, input int ia, input bit fl,
                       input logic [NREAD*AW-1:0] ra);
    exp_t e;
    int   a, cnt;
    @(negedge clk);
    rstn = rs; wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    iss_en = ie; iss_addr = AW'(ia); flush = fl; rd_addr = ra;
    if (!rs) model_reset();
    for (int i = 0; i < NREAD; i++) begin
      a = int'(ra[i*AW +: AW]);
      if (a == 0)                 e.rd_data[i*XLEN +: XLEN] = '0;
      else if (we && wa == a)     e.rd_data[i*XLEN +: XLEN] = wd;
      else                        e.rd_data[i*XLEN +: XLEN] = m_rf[a];
      e.rd_busy[i] = (a != 0) && m_pend[a] && !(we && wa == a);
    end
    cnt = 0;
    for (int r = 0; r < NREG; r++) begin
      e.busy[r] = m_pend[r];
      cnt += int'(m_pend[r]);
    end
    e.npend = (AW+1)'(cnt);
    e.dbg   = m_rf[DBG_REG][15:0];
    q.push_back(e);
    if (rs) begin
      if (we && wa != 0) m_rf[wa] = wd;
      if (fl) begin
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
      end else begin
        if (we && wa != 0) m_pend[wa] = 0;
        if (ie && ia != 0) m_pend[ia] = 1;
      end
    end
  endtask

  function automatic logic [NREAD*AW-1:0] ra3(input int a0, input int a1, input int a2);
    logic [NREAD*AW-1:0] v;
    v = {AW'(a2), AW'(a1), AW'(a0)};
    return v;
  endfunction

  task automatic idle(input int a0);
    drive(1, 0, 0, '0, 0, 0, 0, ra3(a0, 0, DBG_REG));
  endtask

  // Monitor: the DUT presents a fresh view every cycle; compare mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data",  128'(rd_data),  128'(e.rd_data));
        chk("rd_busy",  128'(rd_busy),  128'(e.rd_busy));
        chk("busy_vec", 128'(busy_vec), 128'(e.busy));
        chk("npend",    128'(npend),    128'(e.npend));
        chk("dbg_led",  128'(dbg_led),  128'(e.dbg));
      end
    end
  end

  initial begin
    logic [NREAD*AW-1:0] ra;
    int wa, ia;
    rstn = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0; rd_addr = '0;
    model_reset();

    // Reset, including asynchronous assertion away from a posedge
    drive(0, 0, 0, '0, 0, 0, 0, ra3(5, 0, 0));
    drive(1, 1, 5, 32'hDEADBEEF, 1, 6, 0, ra3(5, 6, 0));
    idle(5);
    drive(0, 0, 0, '0, 0, 0, 0, ra3(5, 6, 2));
    drive(0, 0, 0, '0, 0, 0, 0, ra3(5, 6, 2));

    // Zero register
    drive(1, 1, 0, 32'h1234, 1, 0, 0, ra3(0, 0, 0));
    idle(0);

    // Bypass and debug tap
    drive(1, 1, 3, 32'h11, 0, 0, 0, ra3(1, 0, 0));
    drive(1, 1, 3, 32'h22, 0, 0, 0, ra3(3, 3, 0));
    idle(3);
    drive(1, 1, 2, 32'h00050022, 0, 0, 0, ra3(2, 3, 0));
    idle(2);

    // Issue / writeback
    drive(1, 0, 0, '0, 1, 7, 0, ra3(7, 0, 0));
    idle(7);
    drive(1, 1, 7, 32'hAB, 0, 0, 0, ra3(7, 7, 0));
    idle(7);

    // Simultaneous issue and writeback
    drive(1, 0, 0, '0, 1, 4, 0, ra3(4, 0, 0));
    drive(1, 1, 4, 32'h44, 1, 4, 0, ra3(4, 0, 0));
    drive(1, 1, 4, 32'h45, 1, 9, 0, ra3(4, 9, 0));
    drive(1, 1, 4, 32'h46, 0, 0, 0, ra3(4, 9, 0));
    idle(9);

    // Flush
    drive(1, 1, 9, 32'h99, 1, 1, 0, ra3(1, 0, 0));
    drive(1, 0, 0, '0, 1, 2, 0, ra3(1, 2, 0));
    drive(1, 0, 0, '0, 1, 3, 0, ra3(1, 2, 3));
    drive(1, 1, 1, 32'h77, 1, 6, 1, ra3(1, 6, 3));
    idle(1);
    drive(1, 0, 0, '0, 0, 0, 0, ra3(1, 6, 2));

    // Randomised traffic, biased to a small register set to force collisions
    for (int n = 0; n < 600; n++) begin
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1)) : int'($urandom_range(0, 7));
      ia = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1)) : int'($urandom_range(0, 7));
      for (int i = 0; i < NREAD; i++) begin
        ra[i*AW +: AW] = ($urandom_range(0, 2) == 0) ? AW'(wa) : AW'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 1) == 1, ia, $urandom_range(0, 19) == 0, ra);
    end
    idle(0);

    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
    #5;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in scoreboard, the successor to the single-issue core register file. It provides NREAD combinational read ports with same-cycle write bypass, one write (writeback) port, a hardwired-zero register 0, and a per-register pending bit set at issue and cleared at writeback. It sits between decode/issue (read and issue ports) and writeback (write port) in the pipelined core, and exports a 16-bit debug tap for the board LEDs.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, ≥ 2
- NREAD, 2, number of read ports, 1..4
- DBG_REG, 2, register index driven onto dbg_led
- AW (localparam) = $clog2(NREG)

- clk  in  1  clock; all state updates on posedge
- rstn  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD*AW  read addresses; port i in bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data; port i in bits [i*XLEN +: XLEN]
- rd_busy  out  NREAD  port i's register is pending and not being written back this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback data
- iss_en  in  1  issue strobe: mark iss_addr pending
- iss_addr  in  AW  destination of issuing instruction
- flush  in  1  clear all pending bits (pipeline flush)
- busy_vec  out  NREG  registered pending bits, bit 0 always 0
- npend  out  AW+1  registered count of set pending bits
- dbg_led  out  16  rf[DBG_REG][15:0]

## Operation
- Storage: NREG × XLEN registers, pending[NREG], counter npend.
- Reset (rstn=0, asynchronous): every register = 0, pending = 0, npend = 0; so rd_data = 0, rd_busy = 0, busy_vec = 0, dbg_led = 0. Reset mid-operation discards all pending state.
- Register 0: reads always return 0, never busy; writes and issues to address 0 are ignored (no storage, no pending, no count change).
- Read port i (combinational): if rd_addr_i == 0 → 0; else if wr_en && wr_addr == rd_addr_i → wr_data (bypass); else rf[rd_addr_i].
- rd_busy_i = pending[rd_addr_i] && !(wr_en && wr_addr == rd_addr_i); 0 for address 0.
- Write: wr_en && wr_addr ≠ 0 → rf[wr_addr] ← wr_data at posedge.
- Pending update at posedge, in priority order:
  - flush=1: all pending ← 0, npend ← 0; iss_en ignored this cycle; the write still occurs.
  - else per register r ≠ 0: set = iss_en && iss_addr == r; clr = wr_en && wr_addr == r; next = set ? 1 : (clr ? 0 : pending[r]). Issue and writeback to the same register in the same cycle leaves it pending (new producer wins).
- npend (no flush): +1 if iss sets a bit that was 0; −1 if writeback clears a bit that was 1 and the same register is not issued; otherwise unchanged. Net zero when issue and writeback hit different registers with one set and one cleared. npend always equals popcount(busy_vec); never wraps (max NREG−1).
- Writeback to a non-pending register: data written, pending and npend unchanged.
- dbg_led reflects stored value (no bypass); 0 when XLEN < 16 bits are absent (zero-extend).

## Timing
- Read data and rd_busy: zero latency, combinational from rd_addr, wr_*, and state.
- Write visible to reads the same cycle via bypass, and from storage the next cycle.
- busy_vec and npend update one cycle after the iss/wr/flush edge.
- dbg_led updates the cycle after the write.
- No handshake; the caller must not issue while the rd_busy of its sources is 1 (not checked).

## Test plan
- Reset: hold rstn=0 after writing rf[5]=0xDEADBEEF → rd_data=0, busy_vec=0, npend=0, dbg_led=0; rstn asserted asynchronously mid-cycle clears immediately.
- Zero register: wr_en, wr_addr=0, wr_data=0x1234, iss_en iss_addr=0 → read port 0 addr 0 returns 0, rd_busy=0, npend=0.
- Bypass: rf[3]=0x11; same cycle wr_en addr 3 data 0x22 with rd_addr0=3 → rd_data0=0x22; next cycle, without write, still 0x22; dbg_led=0x0022 after write to reg 2 of 0x00050022.
- Scoreboard: issue r7 → next cycle busy_vec[7]=1, npend=1, rd_busy=1 for addr 7; writeback r7 0xAB → rd_busy=0 that cycle, rd_data=0xAB, next cycle npend=0.
- Simultaneous: r4 pending; issue r4 and writeback r4 same cycle → busy_vec[4] stays 1, npend unchanged; issue r9 + writeback r4 → npend unchanged, bits swap.
- Flush: pending r1, r2, r3 (npend=3); flush with iss_en r6 and wr_en r1 0x77 → next cycle busy_vec=0, npend=0, rf[1]=0x77.
